axis_cfg_bank: RTL

AXIS_CFG_BANK -- requirements
Module: axis_cfg_bank

---
 rtl/axis_cfg_bank_if.sv | 13 +
 rtl/axis_cfg_bank.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/axis_cfg_bank_if.sv
// Stream link (tdata/tvalid/tready/tlast) shared by the config input and
// status readback ports of axis_cfg_bank.
interface axis_cfg_bank_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_cfg_bank.sv
// Stream-loaded configuration bank with status readback frames.
// Optional AXIS_CFG_BANK_ERRCNT_EN prepends a {err_cnt, commit_cnt} word to every status frame.
module axis_cfg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int CFG_WORDS  = 5,
  parameter int STS_WORDS  = 1,
  parameter logic [CFG_WORDS*DATA_WIDTH-1:0] CFG_INIT = '0
) (
  input  logic                            clk,
  input  logic                            aresetn,
  axis_cfg_bank_if.slave                  s_axis,
  axis_cfg_bank_if.master                 m_axis,
  output logic [CFG_WORDS*DATA_WIDTH-1:0] cfg,
  output logic                            cfg_update,
  output logic                            frame_err,
  input  logic [STS_WORDS*DATA_WIDTH-1:0] sts
);

`ifdef AXIS_CFG_BANK_ERRCNT_EN
  localparam int FRAME_WORDS = STS_WORDS + 1;
`else
  localparam int FRAME_WORDS = STS_WORDS;
`endif
  localparam int CW = CFG_WORDS * DATA_WIDTH;
  localparam int FW = FRAME_WORDS * DATA_WIDTH;
  localparam logic [3:0] LAST_IDX   = 4'(CFG_WORDS - 1);
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_WORDS - 1);
  localparam logic [0:0] ST_RECV    = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [0:0]            state_r;
  logic [3:0]            wptr_r;
  logic [CW-1:0]         shadow_r;
  logic [CW-1:0]         shadow_nx_s;
  logic [CW-1:0]         cfg_r;
  logic                  cfg_update_r;
  logic                  frame_err_r;
  logic                  accept_s;
  logic                  commit_s;
  logic                  err_s;
  logic                  trig_s;
  logic [FW-1:0]         frame_s;
  logic [FW-1:0]         snap_r;
  logic [DATA_WIDTH-1:0] mdata_r;
  logic                  mvalid_r;
  logic                  mlast_r;
  logic                  pending_r;
  logic [4:0]            idx_r;
  logic                  done_s;
  logic                  advance_s;
  logic                  load_s;

  assign s_axis.tready = aresetn;
  assign accept_s = s_axis.tvalid & aresetn;
  assign commit_s = accept_s & s_axis.tlast & (state_r == ST_RECV) & (wptr_r == LAST_IDX);
  assign err_s    = accept_s & s_axis.tlast & ~commit_s;
  assign trig_s   = commit_s | err_s;

  // Shadow image with the incoming word merged at the write pointer
  always_comb begin
    shadow_nx_s = shadow_r;
    shadow_nx_s[int'(wptr_r)*DATA_WIDTH +: DATA_WIDTH] = s_axis.tdata;
  end

  // Receive side: fill shadow, commit on a well-formed frame, drop over-long frames
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= ST_RECV;
      wptr_r       <= 4'd0;
      shadow_r     <= CFG_INIT;
      cfg_r        <= CFG_INIT;
      cfg_update_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      cfg_update_r <= commit_s;
      frame_err_r  <= err_s;
      if (accept_s) begin
        case (state_r)
          ST_RECV: begin
            shadow_r <= shadow_nx_s;
            if (s_axis.tlast) begin
              wptr_r <= 4'd0;
              if (commit_s) begin
                cfg_r <= shadow_nx_s;
              end
            end else if (wptr_r == LAST_IDX) begin
              state_r <= ST_DISCARD;
              wptr_r  <= 4'd0;
            end else begin
              wptr_r <= wptr_r + 4'd1;
            end
          end
          ST_DISCARD: begin
            if (s_axis.tlast) begin
              state_r <= ST_RECV;
            end
            wptr_r <= 4'd0;
          end
          default: begin
            state_r <= ST_RECV;
            wptr_r  <= 4'd0;
          end
        endcase
      end
    end
  end

`ifdef AXIS_CFG_BANK_ERRCNT_EN
  logic [15:0] commit_cnt_r;
  logic [15:0] err_cnt_r;
  logic [15:0] commit_cnt_nx_s;
  logic [15:0] err_cnt_nx_s;

  // Counts include the event of the current edge so the snapshot reflects it
  assign commit_cnt_nx_s = (commit_s && (commit_cnt_r != 16'hFFFF)) ? commit_cnt_r + 16'd1 : commit_cnt_r;
  assign err_cnt_nx_s    = (err_s && (err_cnt_r != 16'hFFFF)) ? err_cnt_r + 16'd1 : err_cnt_r;

  // Saturating commit / error event counters
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      commit_cnt_r <= 16'd0;
      err_cnt_r    <= 16'd0;
    end else begin
      commit_cnt_r <= commit_cnt_nx_s;
      err_cnt_r    <= err_cnt_nx_s;
    end
  end

  assign frame_s = {sts, DATA_WIDTH'({err_cnt_nx_s, commit_cnt_nx_s})};
`else
  assign frame_s = sts;
`endif

  assign done_s    = mvalid_r & m_axis.tready & mlast_r;
  assign advance_s = mvalid_r & m_axis.tready & ~mlast_r;
  // A pending frame starts back-to-back on the last handshake of the current one
  assign load_s    = (~mvalid_r | done_s) & (trig_s | pending_r);

  // Status readback: snapshot on start, then walk the snapshot word by word
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      snap_r    <= '0;
      mdata_r   <= '0;
      mvalid_r  <= 1'b0;
      mlast_r   <= 1'b0;
      idx_r     <= 5'd0;
      pending_r <= 1'b0;
    end else if (load_s) begin
      snap_r    <= frame_s;
      mdata_r   <= frame_s[DATA_WIDTH-1:0];
      mvalid_r  <= 1'b1;
      mlast_r   <= (FRAME_LAST == 5'd0);
      idx_r     <= 5'd1;
      pending_r <= 1'b0;
    end else begin
      if (trig_s) begin
        pending_r <= 1'b1;
      end
      if (advance_s) begin
        mdata_r <= snap_r[int'(idx_r)*DATA_WIDTH +: DATA_WIDTH];
        mlast_r <= (idx_r == FRAME_LAST);
        idx_r   <= idx_r + 5'd1;
      end else if (done_s) begin
        mvalid_r <= 1'b0;
        mlast_r  <= 1'b0;
      end
    end
  end

  assign m_axis.tdata  = mdata_r;
  assign m_axis.tvalid = mvalid_r;
  assign m_axis.tlast  = mlast_r;
  assign cfg           = cfg_r;
  assign cfg_update    = cfg_update_r;
  assign frame_err     = frame_err_r;

endmodule
